// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and captures the returned word into IF/ID.
// Edge priority is reset > redirect > stall > advance.

`ifndef I_WIDTH
`define I_WIDTH 32
`endif
`ifndef I_ADD_SIZE
`define I_ADD_SIZE 32
`endif

module fetch_stage #(
    parameter int               WIDTH    = `I_WIDTH,
    parameter int               ADD_SIZE = `I_ADD_SIZE,
    parameter logic [31:0]      RESET_PC = 32'h0000_0000,
    parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_stall,
    input  logic                i_redirect,
    input  logic [31:0]         i_target,
    output logic [ADD_SIZE-1:0] o_imem_addr,
    input  logic [WIDTH-1:0]    i_imem_instr,
    output logic [31:0]         o_pc,
    output logic [WIDTH-1:0]    o_if_id_instr,
    output logic [31:0]         o_if_id_pc,
    output logic [31:0]         o_if_id_pc4,
    output logic                o_if_id_valid,
    output logic                o_if_id_fault,
    output logic [31:0]         o_fetch_count
);

    logic [31:0]      pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [31:0]      ifpc_q, ifpc_d;
    logic [31:0]      ifpc4_q, ifpc4_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic             fault_pend_q, fault_pend_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Next state: redirect flushes and retargets, stall holds, otherwise advance.
    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        ifpc_d       = ifpc_q;
        ifpc4_d      = ifpc4_q;
        valid_d      = valid_q;
        fault_d      = fault_q;
        fault_pend_d = fault_pend_q;
        cnt_d        = cnt_q;
        if (i_redirect) begin
            // The branch is older than whatever caused the stall, so it wins.
            pc_d         = {i_target[31:2], 2'b00};
            instr_d      = NOP;
            valid_d      = 1'b0;
            fault_d      = 1'b0;
            // Misalignment is reported on the target's slot, one edge later.
            fault_pend_d = |i_target[1:0];
        end else if (!i_stall) begin
            pc_d         = pc_plus4;
            instr_d      = i_imem_instr;
            ifpc_d       = pc_q;
            ifpc4_d      = pc_plus4;
            valid_d      = 1'b1;
            fault_d      = fault_pend_q;
            fault_pend_d = 1'b0;
            cnt_d        = cnt_q + 32'd1;
        end
    end

    // State registers with synchronous reset overriding everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q         <= RESET_PC;
            instr_q      <= NOP;
            ifpc_q       <= 32'h0000_0000;
            ifpc4_q      <= 32'h0000_0004;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
            fault_pend_q <= 1'b0;
            cnt_q        <= 32'h0000_0000;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            ifpc_q       <= ifpc_d;
            ifpc4_q      <= ifpc4_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
            fault_pend_q <= fault_pend_d;
            cnt_q        <= cnt_d;
        end
    end

    assign o_imem_addr   = pc_q[ADD_SIZE-1:0];
    assign o_pc          = pc_q;
    assign o_if_id_instr = instr_q;
    assign o_if_id_pc    = ifpc_q;
    assign o_if_id_pc4   = ifpc4_q;
    assign o_if_id_valid = valid_q;
    assign o_if_id_fault = fault_q;
    assign o_fetch_count = cnt_q;

endmodule
